// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and per-stage shift helper for the rotate/shift pipeline
package shifter_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 64;

  localparam logic [OP_W-1:0] OP_ROL = 3'b000;
  localparam logic [OP_W-1:0] OP_ROR = 3'b001;
  localparam logic [OP_W-1:0] OP_LSL = 3'b010;
  localparam logic [OP_W-1:0] OP_LSR = 3'b011;
  localparam logic [OP_W-1:0] OP_ASR = 3'b100;

  // Shift a w-bit value (held in the low bits of d) by s, 0 < s < w; w and s fold to constants.
  function automatic logic [MAX_W-1:0] stage_shift(input logic [MAX_W-1:0] d,
                                                   input logic [OP_W-1:0]  op,
                                                   input int unsigned      w,
                                                   input int unsigned      s);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] dm;
    logic [MAX_W-1:0] fill;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    dm   = d & mask;
    fill = (|(dm >> (w - 1))) ? (mask & ~(mask >> s)) : '0;
    case (op)
      OP_ROL:  stage_shift = ((dm << s) | (dm >> (w - s))) & mask;
      OP_ROR:  stage_shift = ((dm >> s) | (dm << (w - s))) & mask;
      OP_LSL:  stage_shift = (dm << s) & mask;
      OP_LSR:  stage_shift = dm >> s;
      OP_ASR:  stage_shift = (dm >> s) | fill;
      default: stage_shift = dm;
    endcase
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered log-shifter stage (shift by 2^K), flags with SHIFTER_FLAGS_EN
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [OP_W-1:0]  i_op,
  input  logic [AW-1:0]    i_amt,
`ifdef SHIFTER_FLAGS_EN
  input  logic             i_carry,
  output logic             o_carry,
  output logic             o_zero,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [OP_W-1:0]  o_op,
  output logic [AW-1:0]    o_amt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [OP_W-1:0]  r_op;
  logic [AW-1:0]    r_amt;
  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = i_amt[K] ? WIDTH'(stage_shift(MAX_W'(i_data), i_op, WIDTH, 1 << K)) : i_data;

`ifdef SHIFTER_FLAGS_EN
  logic r_carry;
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_load && i_valid) begin
      r_carry <= i_carry;
      r_zero  <= (w_shifted == '0);
    end
  end

  assign o_carry = r_carry;
  assign o_zero  = r_zero;
`endif

  // Payload only moves with a valid op, so idle-cycle garbage never reaches the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_op    <= '0;
      r_amt   <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_shifted;
        r_op   <= i_op;
        r_amt  <= i_amt;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_op    = r_op;
  assign o_amt   = r_amt;

endmodule

// File: rtl/pipelined_rotate_shifter.sv
// rtl/pipelined_rotate_shifter.sv - log2(WIDTH)-stage rotate/shift pipeline with valid/ready flow
// SHIFTER_FLAGS_EN adds out_carry/out_zero, pipelined alongside the data.
module pipelined_rotate_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFTER_FLAGS_EN
  output logic             out_carry,
  output logic             out_zero,
`endif
  output logic [WIDTH-1:0] out_data
);

  logic [AW:0]      w_valid;
  logic [AW-1:0]    w_load;
  logic [WIDTH-1:0] w_data [0:AW];
  logic [OP_W-1:0]  w_op   [0:AW];
  logic [AW-1:0]    w_amt  [0:AW];

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_op[0]    = in_op;
  assign w_amt[0]   = in_amt;

`ifdef SHIFTER_FLAGS_EN
  logic [AW:0]   w_carry;
  logic          w_zero [0:AW-1];
  logic [AW-1:0] w_amt_neg;
  logic [AW-1:0] w_amt_m1;
  logic          w_carry_in;

  assign w_amt_neg = -in_amt;
  assign w_amt_m1  = in_amt - 1'b1;

  // Carry depends only on the original operand, so it is resolved on entry and just carried along.
  always_comb begin
    w_carry_in = 1'b0;
    if (in_amt != '0) begin
      case (in_op)
        OP_ROL, OP_LSL:         w_carry_in = in_data[w_amt_neg];
        OP_ROR, OP_LSR, OP_ASR: w_carry_in = in_data[w_amt_m1];
        default:                w_carry_in = 1'b0;
      endcase
    end
  end

  assign w_carry[0] = w_carry_in;
  assign out_carry  = w_carry[AW];
  assign out_zero   = w_zero[AW-1];
`endif

  for (genvar k = 0; k < AW; k++) begin : g_stage
    // A stage loads when some stage at or after it is empty, or the output drains.
    assign w_load[k] = out_ready | ~(&w_valid[AW:k+1]);

    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_op    (w_op[k]),
      .i_amt   (w_amt[k]),
`ifdef SHIFTER_FLAGS_EN
      .i_carry (w_carry[k]),
      .o_carry (w_carry[k+1]),
      .o_zero  (w_zero[k]),
`endif
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_op    (w_op[k+1]),
      .o_amt   (w_amt[k+1])
    );
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_valid[AW];
  assign out_data  = w_data[AW];

endmodule

// File: tb/tb_pipelined_rotate_shifter.sv
// tb/tb_pipelined_rotate_shifter.sv - directed and random self-checking bench for the shifter pipeline
module tb_pipelined_rotate_shifter;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFTER_FLAGS_EN
  logic             out_carry;
  logic             out_zero;
`endif

  pipelined_rotate_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFTER_FLAGS_EN
    .out_carry (out_carry),
    .out_zero  (out_zero),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         chk_lat;
  bit         last_acc;
  logic [7:0] nx_d;
  logic       nx_c;
  logic [7:0] q_d[$];
  logic       q_c[$];
  int         q_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; transfers are sampled 1ns later.
  task automatic tick();
    logic [7:0] d;
    logic       c;
    int         a;
    #1;
    if (out_valid && out_ready) begin
      if (q_d.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        d = q_d.pop_front();
        c = q_c.pop_front();
        a = q_cyc.pop_front();
        chk("out_data", 32'(out_data), 32'(d));
`ifdef SHIFTER_FLAGS_EN
        chk("out_carry", 32'(out_carry), 32'(c));
        chk("out_zero", 32'(out_zero), 32'(d == 8'h00));
`endif
        if (chk_lat) chk("latency", 32'(cyc - a), 32'd3);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      q_d.push_back(nx_d);
      q_c.push_back(nx_c);
      q_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d,
                      input logic [7:0] e, input logic c);
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = d;
    nx_d     = e;
    nx_c     = c;
    last_acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc) break;
      out_ready = 1'b1;
    end
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = 'x;
    in_op    = 'x;
    in_amt   = 'x;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q_d.size() == 0) break;
      tick();
    end
    chk("drain_left", 32'(q_d.size()), 32'd0);
    repeat (2) tick();
  endtask

  function automatic logic [8:0] ref_model(input logic [2:0] op, input logic [2:0] amt,
                                           input logic [7:0] d);
    logic [7:0] r;
    logic       c;
    int         a;
    r = '0;
    c = 1'b0;
    a = int'(amt);
    for (int i = 0; i < 8; i++) begin
      case (op)
        3'd0:    r[3'(i)] = d[3'(i - a)];
        3'd1:    r[3'(i)] = d[3'(i + a)];
        3'd2:    r[3'(i)] = (i >= a) ? d[3'(i - a)] : 1'b0;
        3'd3:    r[3'(i)] = (i + a < 8) ? d[3'(i + a)] : 1'b0;
        3'd4:    r[3'(i)] = (i + a < 8) ? d[3'(i + a)] : d[7];
        default: r[3'(i)] = d[3'(i)];
      endcase
    end
    if (a != 0) begin
      case (op)
        3'd0:       c = r[0];
        3'd1:       c = r[7];
        3'd2:       c = d[3'(8 - a)];
        3'd3, 3'd4: c = d[3'(a - 1)];
        default:    c = 1'b0;
      endcase
    end
    return {c, r};
  endfunction

  initial begin
    logic [7:0] rol_exp [0:7];
    logic       rol_c   [0:7];
    logic [8:0] m;
    logic [2:0] rop;
    logic [2:0] ramt;
    logic [7:0] rd;

    rol_exp = '{8'h7B, 8'hF6, 8'hED, 8'hDB, 8'hB7, 8'h6F, 8'hDE, 8'hBD};
    rol_c   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_op     = 'x;
    in_amt    = 'x;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

    // reset with three ops in flight
    send(3'b000, 3'd1, 8'h7B, 8'hF6, 1'b0);
    send(3'b001, 3'd1, 8'h7B, 8'hBD, 1'b1);
    send(3'b010, 3'd2, 8'h7B, 8'hEC, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    q_d.delete();
    q_c.delete();
    q_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("no_stale", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // ops on 01111011
    send(3'b000, 3'd3, 8'h7B, 8'hDB, 1'b1);
    send(3'b001, 3'd1, 8'h7B, 8'hBD, 1'b1);
    send(3'b010, 3'd2, 8'h7B, 8'hEC, 1'b1);
    send(3'b000, 3'd0, 8'h7B, 8'h7B, 1'b0);
    send(3'b011, 3'd0, 8'h7B, 8'h7B, 1'b0);
    drain();

    // sign/zero fill and pass-through on 10000110
    send(3'b100, 3'd2, 8'h86, 8'hE1, 1'b1);
    send(3'b011, 3'd3, 8'h86, 8'h10, 1'b1);
    send(3'b111, 3'd5, 8'h86, 8'h86, 1'b0);
    send(3'b101, 3'd2, 8'h86, 8'h86, 1'b0);
    drain();

    // back-to-back ROL sweep
    for (int i = 0; i < 8; i++) send(3'b000, 3'(i), 8'h7B, rol_exp[i], rol_c[i]);
    drain();

    // backpressure: three accepted, fourth blocked while output stalls
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(3'b000, 3'd1, 8'h7B, 8'hF6, 1'b0);
    send(3'b001, 3'd1, 8'h7B, 8'hBD, 1'b1);
    send(3'b010, 3'd2, 8'h7B, 8'hEC, 1'b1);
    in_valid = 1'b1;
    in_op    = 3'b100;
    in_amt   = 3'd2;
    in_data  = 8'h86;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h0F6);
      tick();
    end
    out_ready = 1'b1;
    send(3'b100, 3'd2, 8'h86, 8'hE1, 1'b1);
    drain();

    // flags corner and random traffic against the reference model
    send(3'b011, 3'd1, 8'h01, 8'h00, 1'b1);
    drain();
    for (int i = 0; i < 1000; i++) begin
      rop       = 3'($urandom_range(0, 7));
      ramt      = 3'($urandom_range(0, 7));
      rd        = 8'($urandom);
      m         = ref_model(rop, ramt, rd);
      out_ready = ($urandom_range(0, 3) != 0);
      send(rop, ramt, rd, m[7:0], m[8]);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
